// File: rtl/shift_tx_sequencer.sv
// shift_tx_sequencer: drives an external N-bit shift register's load/shift controls to serialise words.
// Handshake-to-done latency 1 + N*DIV cycles; tx_ready stays low while a word is in flight (LOAD/SHIFT/GAP).
module shift_tx_sequencer #(
    parameter int   N    = 4,
    parameter int   DIV  = 4,
    parameter int   GAP  = 1,
    parameter logic FILL = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 abort,
    output logic [N-1:0]         sr_par,
    output logic                 sr_load,
    output logic                 sr_en,
    output logic                 sr_in,
    output logic                 busy,
    output logic [$clog2(N)-1:0] bit_idx,
    output logic                 done
);
    localparam int BW = $clog2(N);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW = (GAP * DIV > 1) ? $clog2(GAP * DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP * DIV - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_div;
    logic [BW-1:0] r_bit;
    logic [GW-1:0] r_gap;
    logic [N-1:0]  r_hold;
    logic          r_live;

    logic w_in_flight;
    logic w_abort;
    logic w_tick;
    logic w_last;

    assign w_in_flight = (r_state != S_IDLE);
    assign w_abort     = abort & w_in_flight;
    assign w_tick      = (r_state == S_SHIFT) && (r_div == DIV_LAST);
    assign w_last      = w_tick && (r_bit == BIT_LAST);

    // r_live keeps tx_ready low until the first clock edge after reset release.
    assign tx_ready = r_live & ~w_in_flight & ~abort;
    assign sr_load  = (r_state == S_LOAD) & ~abort;
    assign sr_en    = ((r_state == S_LOAD) | w_tick) & ~abort;
    assign done     = w_last & ~abort;
    assign busy     = w_in_flight;
    assign bit_idx  = (r_state == S_SHIFT) ? r_bit : '0;
    assign sr_par   = r_hold;
    assign sr_in    = FILL;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_gap   <= '0;
            r_hold  <= '0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_abort) begin
                r_state <= S_IDLE;
                r_div   <= '0;
                r_bit   <= '0;
                r_gap   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (tx_valid && tx_ready) begin
                            r_hold  <= tx_data;
                            r_state <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_gap   <= '0;
                        r_state <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (r_div == DIV_LAST) begin
                            r_div <= '0;
                            if (r_bit == BIT_LAST) begin
                                r_bit   <= '0;
                                r_state <= (GAP > 0) ? S_GAP : S_IDLE;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (r_gap == GAP_LAST) begin
                            r_gap   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_shift_tx_sequencer.sv
// Bench for shift_tx_sequencer: one instance with N=4/DIV=4/GAP=1 and one with N=4/DIV=1/GAP=0,
// each driving a bench-side model of the external shift register.
module tb_shift_tx_sequencer;
    logic       clk       = 1'b0;
    logic       reset_n   = 1'b1;
    logic [3:0] tx_data   = 4'h0;
    logic       tx_valid  = 1'b0;
    logic       abort     = 1'b0;
    logic [3:0] tx_data2  = 4'h0;
    logic       tx_valid2 = 1'b0;
    logic       abort2    = 1'b0;

    logic [3:0] sr_par, sr_par2;
    logic       sr_load, sr_en, sr_in, busy, done, tx_ready;
    logic       sr_load2, sr_en2, sr_in2, busy2, done2, tx_ready2;
    logic [1:0] bit_idx, bit_idx2;

    logic [3:0] q1 = 4'h0;
    logic [3:0] q2 = 4'h0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_tx_sequencer #(.N(4), .DIV(4), .GAP(1), .FILL(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .abort(abort), .sr_par(sr_par), .sr_load(sr_load),
        .sr_en(sr_en), .sr_in(sr_in), .busy(busy), .bit_idx(bit_idx), .done(done)
    );

    shift_tx_sequencer #(.N(4), .DIV(1), .GAP(0), .FILL(1'b1)) dut2 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .abort(abort2), .sr_par(sr_par2), .sr_load(sr_load2),
        .sr_en(sr_en2), .sr_in(sr_in2), .busy(busy2), .bit_idx(bit_idx2), .done(done2)
    );

    // External register model: parallel load, shift right, serial out at bit 0.
    always @(posedge clk) begin
        if (sr_en)  q1 <= sr_load  ? sr_par  : {sr_in,  q1[3:1]};
        if (sr_en2) q2 <= sr_load2 ? sr_par2 : {sr_in2, q2[3:1]};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 reset_n = 1'b0;
        #2;
        checks++;
        if ({tx_ready, busy, sr_load, sr_en, done} !== 5'b0) begin
            failures++;
            $display("FAIL rst_ctrl got=%b want=00000", {tx_ready, busy, sr_load, sr_en, done});
        end
        checks++;
        if ({bit_idx, sr_par} !== 6'h0) begin
            failures++;
            $display("FAIL rst_data got=%h want=00", {bit_idx, sr_par});
        end
        #20 reset_n = 1'b1;
        tick;
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_release ready=%b busy=%b want ready=1 busy=0", tx_ready, busy);
        end
        // Start a word and hit reset on a cycle where sr_en would be high.
        tx_data = 4'b0110; tx_valid = 1'b1;
        #1;
        tick;
        tx_valid = 1'b0;
        #1;
        checks++;
        if (sr_load !== 1'b1 || sr_en !== 1'b1) begin
            failures++;
            $display("FAIL rst_load_cycle sr_load=%b sr_en=%b want 1 1", sr_load, sr_en);
        end
        repeat (4) tick;
        checks++;
        if (sr_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_shift sr_en=%b busy=%b want 1 1", sr_en, busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({tx_ready, busy, sr_load, sr_en, done, bit_idx, sr_par} !== 11'h0) begin
            failures++;
            $display("FAIL rst_mid_shift got=%h want=000",
                     {tx_ready, busy, sr_load, sr_en, done, bit_idx, sr_par});
        end
        #2 reset_n = 1'b1;
        tick;
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rst_after ready=%b busy=%b done=%b want 1 0 0", tx_ready, busy, done);
        end
    endtask

    task automatic test_single_word;
        logic [3:0] w;
        logic       exp_en;
        w = 4'b1011;
        tx_data = w; tx_valid = 1'b1;
        #1;
        checks++;
        if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL sw_ready_idle got=%b want=1", tx_ready);
        end
        tick;
        tx_valid = 1'b0;
        for (int t = 0; t <= 21; t++) begin
            #1;
            exp_en = (t == 0) || (t >= 4 && t <= 16 && t % 4 == 0);
            checks++;
            if (sr_en !== exp_en) begin
                failures++;
                $display("FAIL sw_sr_en t=%0d got=%b want=%b", t, sr_en, exp_en);
            end
            checks++;
            if (done !== (t == 16)) begin
                failures++;
                $display("FAIL sw_done t=%0d got=%b want=%b", t, done, (t == 16));
            end
            checks++;
            if (tx_ready !== (t == 21)) begin
                failures++;
                $display("FAIL sw_ready t=%0d got=%b want=%b", t, tx_ready, (t == 21));
            end
            checks++;
            if (bit_idx !== ((t >= 1 && t <= 16) ? 2'((t - 1) / 4) : 2'd0)) begin
                failures++;
                $display("FAIL sw_bit_idx t=%0d got=%0d", t, bit_idx);
            end
            if (t >= 1 && t <= 16) begin
                checks++;
                if (q1[0] !== w[(t - 1) / 4]) begin
                    failures++;
                    $display("FAIL sw_serial t=%0d got=%b want=%b", t, q1[0], w[(t - 1) / 4]);
                end
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] w0, w1;
        logic       exp_en;
        int         e;
        int         rise;
        w0 = 4'hA; w1 = 4'h5; rise = -1;
        tx_data = w0; tx_valid = 1'b1;
        #1;
        tick;
        tx_data = w1;
        for (int t = 0; t <= 43; t++) begin
            if (t == 22) tx_valid = 1'b0;
            #1;
            if (tx_ready === 1'b1 && rise < 0) rise = t;
            e = (t < 22) ? t : t - 22;
            exp_en = (e == 0) || (e >= 4 && e <= 16 && e % 4 == 0);
            checks++;
            if (sr_en !== exp_en) begin
                failures++;
                $display("FAIL b2b_sr_en t=%0d got=%b want=%b", t, sr_en, exp_en);
            end
            checks++;
            if (done !== (e == 16) || tx_ready !== (e == 21)) begin
                failures++;
                $display("FAIL b2b_done_ready t=%0d done=%b ready=%b want %b %b",
                         t, done, tx_ready, (e == 16), (e == 21));
            end
            if (t >= 1 && t <= 16) begin
                checks++;
                if (q1[0] !== w0[(t - 1) / 4]) begin
                    failures++;
                    $display("FAIL b2b_serial0 t=%0d got=%b want=%b", t, q1[0], w0[(t - 1) / 4]);
                end
            end
            if (t >= 23 && t <= 38) begin
                checks++;
                if (q1[0] !== w1[(t - 23) / 4]) begin
                    failures++;
                    $display("FAIL b2b_serial1 t=%0d got=%b want=%b", t, q1[0], w1[(t - 23) / 4]);
                end
            end
            tick;
        end
        checks++;
        if (rise != 21) begin
            failures++;
            $display("FAIL b2b_period got=%0d want=21", rise);
        end
    endtask

    task automatic test_gap0_div1;
        logic [3:0] w;
        w = 4'b1001;
        tx_data2 = w; tx_valid2 = 1'b1;
        #1;
        tick;
        tx_valid2 = 1'b0;
        for (int t = 0; t <= 5; t++) begin
            #1;
            checks++;
            if (sr_en2 !== (t <= 4) || sr_load2 !== (t == 0)) begin
                failures++;
                $display("FAIL d1_en_load t=%0d en=%b load=%b want %b %b",
                         t, sr_en2, sr_load2, (t <= 4), (t == 0));
            end
            checks++;
            if (done2 !== (t == 4) || tx_ready2 !== (t == 5)) begin
                failures++;
                $display("FAIL d1_done_ready t=%0d done=%b ready=%b want %b %b",
                         t, done2, tx_ready2, (t == 4), (t == 5));
            end
            if (t >= 1 && t <= 4) begin
                checks++;
                if (q2[0] !== w[t - 1]) begin
                    failures++;
                    $display("FAIL d1_serial t=%0d got=%b want=%b", t, q2[0], w[t - 1]);
                end
            end
            tick;
        end
    endtask

    task automatic test_abort;
        logic [3:0] w;
        logic       exp_en;
        tx_data = 4'hC; tx_valid = 1'b1;
        #1;
        tick;
        tx_valid = 1'b0;
        repeat (12) tick;
        abort = 1'b1;
        #1;
        checks++;
        if (bit_idx !== 2'd2 || sr_en !== 1'b0 || done !== 1'b0 || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL ab_cycle idx=%0d en=%b done=%b ready=%b want 2 0 0 0",
                     bit_idx, sr_en, done, tx_ready);
        end
        tick;
        abort = 1'b0;
        w = 4'h3;
        tx_data = w; tx_valid = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || sr_en !== 1'b0 || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL ab_idle busy=%b en=%b ready=%b want 0 0 1", busy, sr_en, tx_ready);
        end
        tick;
        tx_valid = 1'b0;
        for (int t = 0; t <= 21; t++) begin
            #1;
            exp_en = (t == 0) || (t >= 4 && t <= 16 && t % 4 == 0);
            checks++;
            if (sr_en !== exp_en || done !== (t == 16)) begin
                failures++;
                $display("FAIL ab_next t=%0d en=%b done=%b want %b %b", t, sr_en, done, exp_en, (t == 16));
            end
            if (t >= 1 && t <= 16) begin
                checks++;
                if (q1[0] !== w[(t - 1) / 4]) begin
                    failures++;
                    $display("FAIL ab_serial t=%0d got=%b want=%b", t, q1[0], w[(t - 1) / 4]);
                end
            end
            tick;
        end
    endtask

    task automatic test_abort_final;
        int n;
        tx_data = 4'hF; tx_valid = 1'b1;
        #1;
        tick;
        tx_valid = 1'b0;
        repeat (16) tick;
        abort = 1'b1;
        #1;
        checks++;
        if (sr_en !== 1'b0 || done !== 1'b0 || sr_load !== 1'b0) begin
            failures++;
            $display("FAIL abf_last en=%b done=%b load=%b want 0 0 0", sr_en, done, sr_load);
        end
        tick;
        abort = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL abf_to_idle busy=%b ready=%b want 0 1", busy, tx_ready);
        end
        abort = 1'b1; tx_valid = 1'b1; tx_data = 4'h6;
        #1;
        checks++;
        if (tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL abf_idle_ready got=%b want=0", tx_ready);
        end
        tick;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abf_idle_nohs busy=%b want=0", busy);
        end
        abort = 1'b0;
        #1;
        tick;
        tx_valid = 1'b0;
        #1;
        checks++;
        if (sr_load !== 1'b1 || sr_par !== 4'h6) begin
            failures++;
            $display("FAIL abf_accept load=%b par=%h want 1 6", sr_load, sr_par);
        end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abf_drain timeout busy=%b want=0", busy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single_word;
        test_back_to_back;
        test_gap0_div1;
        test_abort;
        test_abort_final;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_tx_sequencer.md
# shift_tx_sequencer

Controller that sequences an external N-bit shift register (parallel load, shift-right, serial out at bit 0) to serialise parallel words. It accepts words over a valid/ready handshake, drives the register's load/shift controls with a programmable bit period, counts bits, and reports completion. It sits between a word producer and the serialising shift register, which it owns exclusively.

## Interface
- N, 4: word width; must match the controlled register; N >= 2.
- DIV, 4: clock cycles per serial bit; DIV >= 1.
- GAP, 1: idle bit-periods inserted after each word; GAP >= 0.
- FILL, 1'b1: value driven on sr_in, shifted in behind the data.
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tx_data  in  N  word to send; sampled on handshake.
- tx_valid  in  1  producer has a word.
- tx_ready  out  1  controller accepts a word this cycle.
- abort  in  1  synchronous cancel of the current word.
- sr_par  out  N  parallel word to register I input (held word).
- sr_load  out  1  register shift_n_load: 1 = load sr_par.
- sr_en  out  1  register clock enable: register updates only on edges where sr_en = 1.
- sr_in  out  1  serial fill bit, constant FILL.
- busy  out  1  state != IDLE.
- bit_idx  out  clog2(N)  index of bit currently on serial out.
- done  out  1  one-cycle pulse: word fully shifted.

## Operation
- States: IDLE, LOAD, SHIFT, GAP. Registered state, div counter (0..DIV-1), bit counter (0..N-1), gap counter (0..GAP*DIV-1), hold register (N bits).
- IDLE: tx_ready = 1. On tx_valid & tx_ready: hold <= tx_data, go LOAD.
- LOAD (exactly 1 cycle): sr_load = 1, sr_en = 1; counters cleared; go SHIFT.
- SHIFT: div counts every cycle; sr_en = 1 (sr_load = 0) when div == DIV-1, then div wraps to 0 and bit counter increments. On the sr_en cycle with bit == N-1: done = 1; go GAP if GAP > 0, else IDLE.
- GAP: outputs idle for GAP*DIV cycles, then IDLE.
- bit_idx = bit counter in SHIFT, 0 elsewhere. sr_par = hold at all times.
- abort = 1 in any non-IDLE state: next state IDLE, counters cleared; sr_en, sr_load and done forced 0 in that cycle. abort in IDLE ignored; abort has priority over a handshake in the same cycle (tx_ready forced 0 when abort = 1).
- tx_ready = 0 outside IDLE; no word accepted during LOAD/SHIFT/GAP, including the done cycle.
- Reset (asynchronous, any state): state IDLE, all counters and hold = 0. While reset_n = 0: tx_ready = 0, busy = 0, sr_load = 0, sr_en = 0, done = 0, bit_idx = 0, sr_par = 0. Reset mid-word discards the word with no done.

## Timing
- Handshake at edge E0 -> LOAD cycle; register loads at edge E1 = E0+1.
- Data bit k on register serial out from E1 + k*DIV to E1 + (k+1)*DIV, k = 0..N-1; each bit held exactly DIV cycles.
- sr_en asserted at edges E1 + k*DIV, k = 1..N (N shift pulses plus the load pulse).
- done high in the cycle ending at E1 + N*DIV.
- tx_ready high again GAP*DIV cycles after that edge; word-to-word period = 1 + N*DIV + GAP*DIV cycles.
- DIV = 1: sr_en high on every SHIFT cycle.

## Test plan
- Reset: assert reset_n = 0 mid-SHIFT -> all outputs 0 immediately (no clock); after release tx_ready = 1 next cycle, state IDLE.
- Single word, N=4, DIV=4, GAP=1, tx_data = 4'b1011 -> serial out (bench model register) 1,1,0,1 each 4 cycles; sr_en pulses at E1+4/8/12/16; done at E1+16; tx_ready high at E1+20.
- Back-to-back: tx_valid held high with 4'hA then 4'h5 -> second handshake exactly 21 cycles after the first; serial stream 0,1,0,1, gap, 1,0,1,0.
- GAP=0, DIV=1 -> sr_en high 4 consecutive cycles after LOAD, done on 4th, tx_ready high the next cycle.
- Abort on bit 2 -> IDLE next edge, no further sr_en, no done; next word 4'h3 serialised correctly from bit 0.
- Abort coincident with final sr_en cycle -> done = 0, sr_en = 0 that cycle; abort while IDLE with tx_valid = 1 -> no handshake that cycle, accepted the following cycle.
